// File: rtl/btn_walk_requester.sv
// Wishbone master: debounced button press -> start-write to the LED walker,
// then poll its state register until the walk ends and count completed walks.
module btn_walk_requester #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned POLL_INTERVAL   = 8,
    parameter int unsigned ACK_TIMEOUT     = 64,
    parameter logic [31:0] WRITE_WORD      = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_btn,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic        o_addr,
    output logic [31:0] o_data,
    input  logic        i_stall,
    input  logic        i_ack,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic [7:0]  o_walks,
    output logic        o_err
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PT_W = $clog2(POLL_INTERVAL + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PT_W-1:0] PT_LOAD = PT_W'(POLL_INTERVAL - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_ACK, S_WAIT, S_RD_REQ, S_RD_ACK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic            deb_q, deb_d, press_q, press_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [PT_W-1:0] timer_q, timer_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            pend_q, pend_d;
    logic [7:0]      walks_q, walks_d;
    logic            err_q, err_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, busy_q, busy_d;
    logic [31:0]     data_q, data_d;
    logic            timed_out;
    logic            unused_data;

    assign unused_data = ^i_data[31:4];

    // Input path: 2-FF sync, then the level only moves after a full run of
    // differing samples; any sample matching the current level restarts it.
    always_comb begin
        sync1_d  = i_btn;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (db_cnt_q == DB_MAX) deb_d = sync2_q;
            else                    db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d = deb_d & ~deb_q;
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        timer_d   = timer_q;
        to_d      = to_q;
        walks_d   = walks_q;
        err_d     = err_q;
        timed_out = (to_q == TO_MAX);
        case (state_q)
            S_IDLE: begin
                if (press_q || pend_q) begin
                    state_d = S_WR_REQ;
                    pend_d  = 1'b0;
                    to_d    = '0;
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                to_d = to_q + 1'b1;
                if (timed_out) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (!i_stall) begin
                    state_d = (state_q == S_WR_REQ) ? S_WR_ACK : S_RD_ACK;
                end
            end
            S_WR_ACK: begin
                to_d = to_q + 1'b1;
                if (i_ack) begin
                    state_d = S_WAIT;
                    timer_d = PT_LOAD;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (timer_q == '0) begin
                    state_d = S_RD_REQ;
                    to_d    = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_RD_ACK: begin
                to_d = to_q + 1'b1;
                if (i_ack) begin
                    if (i_data[3:0] == 4'd0) begin
                        state_d = S_IDLE;
                        walks_d = walks_q + 8'd1;
                    end else begin
                        state_d = S_WAIT;
                        timer_d = PT_LOAD;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (press_q && state_q != S_IDLE && !pend_q) pend_d = 1'b1;

        cyc_d  = (state_d == S_WR_REQ) || (state_d == S_WR_ACK) ||
                 (state_d == S_RD_REQ) || (state_d == S_RD_ACK);
        stb_d  = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
        we_d   = (state_d == S_WR_REQ);
        data_d = (state_d == S_WR_REQ) ? WRITE_WORD : 32'd0;
        // A queued press keeps busy high through the single IDLE hop.
        busy_d = (state_d != S_IDLE) || pend_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= 1'b0;
            press_q  <= 1'b0;
            db_cnt_q <= '0;
            timer_q  <= '0;
            to_q     <= '0;
            pend_q   <= 1'b0;
            walks_q  <= 8'd0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            data_q   <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
            timer_q  <= timer_d;
            to_q     <= to_d;
            pend_q   <= pend_d;
            walks_q  <= walks_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign o_cyc   = cyc_q;
    assign o_stb   = stb_q;
    assign o_we    = we_q;
    assign o_addr  = 1'b0;
    assign o_data  = data_q;
    assign o_busy  = busy_q;
    assign o_walks = walks_q;
    assign o_err   = err_q;
endmodule
